// File: rtl/reg_bus_read_sequencer_if.sv
// Request/response handshake plus chip-select and shared-bus signals between a
// controller, the read sequencer and the bank of tri-state bus registers.
interface reg_bus_read_sequencer_if #(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4,
  parameter int AddrBits = 2
);
  // valid/ready: a transfer happens on a rising clk edge where valid and ready
  // are both 1; the source holds valid and its payload stable until then, and
  // ready never depends combinationally on valid.
  logic                req_valid;
  logic [AddrBits-1:0] req_addr;
  logic                req_ready;
  logic [NrOfRegs-1:0] cs;
  logic [NrOfBits-1:0] bus_in;
  logic                rsp_valid;
  logic [NrOfBits-1:0] rsp_data;
  logic [AddrBits-1:0] rsp_addr;
  logic                rsp_err;
  logic                rsp_ready;

  modport master (
    output req_valid, req_addr, bus_in, rsp_ready,
    input  req_ready, cs, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, bus_in, rsp_ready,
    output req_ready, cs, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/reg_bus_read_sequencer.sv
// Reads one word at a time from a shared tri-state register bus: selects one
// register, waits a tick-gated settle window, samples the bus and responds.
module reg_bus_read_sequencer #(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  reg_bus_read_sequencer_if.slave      bus,
  output logic [1:0]                   state_dbg
);
  localparam int SettleEff = (SettleCycles < 1) ? 1 : SettleCycles;
  localparam int CntW      = $clog2(SettleEff + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NrOfRegs-1:0] cs_q, cs_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0] rsp_data_q, rsp_data_d;
  logic [AddrBits-1:0] rsp_addr_q, rsp_addr_d;
  logic                rsp_err_q, rsp_err_d;

  // Reset releases every cs asynchronously, so a pending read never keeps a register driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cs_q        <= '1;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (int'(bus.req_addr) < NrOfRegs) begin
            for (int i = 0; i < NrOfRegs; i++) begin
              cs_d[i] = (i != int'(bus.req_addr));
            end
            addr_d  = bus.req_addr;
            cnt_d   = CntW'(SettleEff);
            state_d = SELECT;
          end else begin
            // Out-of-range address: answer immediately without touching the bus.
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_addr_d  = bus.req_addr;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      SELECT: begin
        if (tick) begin
          if (cnt_q == CntW'(1)) begin
            rsp_data_d  = bus.bus_in;
            rsp_addr_d  = addr_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            cs_d        = '1;
            cnt_d       = '0;
            state_d     = RESP;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.cs        = cs_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_reg_bus_read_sequencer.sv
// Directed plus randomised reads against two sequencer instances (4 regs /
// settle 1, and 3 regs / settle 3) with a modelled register bank on each bus.
module tb_reg_bus_read_sequencer;
  localparam int NB = 8;
  localparam int AB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tick = 1'b1;
  logic          tick_alt = 1'b0;
  logic          sel = 1'b0;
  logic          req_valid = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic          rsp_ready = 1'b0;
  logic [1:0]    state_a, state_b;
  logic [NB-1:0] regs_a [4];
  logic [NB-1:0] regs_b [3];
  int            total = 0;
  int            bad = 0;
  logic [10:0]   exp_q[$];

  reg_bus_read_sequencer_if #(.NrOfBits(NB), .NrOfRegs(4), .AddrBits(AB)) if_a ();
  reg_bus_read_sequencer_if #(.NrOfBits(NB), .NrOfRegs(3), .AddrBits(AB)) if_b ();

  reg_bus_read_sequencer #(.NrOfBits(NB), .NrOfRegs(4), .AddrBits(AB), .SettleCycles(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(if_a.slave), .state_dbg(state_a)
  );
  reg_bus_read_sequencer #(.NrOfBits(NB), .NrOfRegs(3), .AddrBits(AB), .SettleCycles(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(if_b.slave), .state_dbg(state_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  assign if_a.req_valid = req_valid && !sel;
  assign if_a.req_addr  = req_addr;
  assign if_a.rsp_ready = rsp_ready && !sel;
  assign if_b.req_valid = req_valid && sel;
  assign if_b.req_addr  = req_addr;
  assign if_b.rsp_ready = rsp_ready && sel;

  // Register bank model: a floating bus reads back as 8'hEE.
  always_comb begin
    if_a.bus_in = 8'hEE;
    for (int i = 0; i < 4; i++) if (!if_a.cs[i]) if_a.bus_in = regs_a[i];
  end
  always_comb begin
    if_b.bus_in = 8'hEE;
    for (int i = 0; i < 3; i++) if (!if_b.cs[i]) if_b.bus_in = regs_b[i];
  end

  logic [3:0]    o_cs;
  logic          o_valid, o_ready;
  logic [10:0]   o_word;
  always_comb begin
    if (sel) begin
      o_cs    = {1'b1, if_b.cs};
      o_valid = if_b.rsp_valid;
      o_ready = if_b.req_ready;
      o_word  = {if_b.rsp_err, if_b.rsp_addr, if_b.rsp_data};
    end else begin
      o_cs    = if_a.cs;
      o_valid = if_a.rsp_valid;
      o_ready = if_a.req_ready;
      o_word  = {if_a.rsp_err, if_a.rsp_addr, if_a.rsp_data};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_alt) tick = ~tick;
  endtask

  // Driver: one read, scoreboard push/pop, latency, hold and handshake checks.
  task automatic do_read(input logic s, input int addr, input int exp_lat, input int exp_low,
                         input int hold, input int chg_at, input logic [NB-1:0] chg_val);
    int            nregs, cycles, low, multi, unstable;
    logic [NB-1:0] d;
    logic [3:0]    exp_cs;
    logic [10:0]   exp_w, seen;
    sel   = s;
    nregs = s ? 3 : 4;
    exp_cs = 4'hF;
    if (addr >= nregs) begin
      exp_q.push_back({1'b1, AB'(addr), 8'h00});
    end else begin
      d = (chg_at >= 0) ? chg_val : (s ? regs_b[addr] : regs_a[addr]);
      exp_q.push_back({1'b0, AB'(addr), d});
      exp_cs[addr] = 1'b0;
    end
    req_valid = 1'b1;
    req_addr  = AB'(addr);
    step();
    req_valid = 1'b0;
    if (tick_alt) tick = 1'b0;
    if (addr < nregs) check("cs_select", o_cs, exp_cs);
    cycles = 0; low = 0; multi = 0;
    while (!o_valid && cycles < 50) begin
      if (o_cs != 4'hF) low++;
      if ($countones(~o_cs) > 1) multi++;
      if (cycles == chg_at) begin
        if (s) regs_b[addr] = chg_val;
        else regs_a[addr] = chg_val;
      end
      step();
      cycles++;
    end
    check("rsp_latency", cycles, exp_lat);
    check("cs_low_cycles", low, exp_low);
    check("cs_multi_low", multi, 0);
    check("cs_free_in_resp", o_cs, 4'hF);
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      check("rsp_word", o_word, exp_w);
    end
    seen = o_word;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!o_valid || o_word !== seen || o_cs !== 4'hF || o_ready) unstable++;
    end
    check("rsp_hold", unstable, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_drop", o_valid, 0);
    check("req_ready_back", o_ready, 1);
    check("rsp_kept", o_word, seen);
  endtask

  initial begin
    int ra, rh, vcount;
    regs_a = '{8'h10, 8'h21, 8'hA5, 8'h43};
    regs_b = '{8'h50, 8'h11, 8'h72};

    // Reset with a request pending
    req_valid = 1'b1;
    req_addr  = 2'd2;
    #1 rst_n = 1'b0;
    #1;
    check("rst_cs", o_cs, 4'hF);
    check("rst_req_ready", o_ready, 0);
    check("rst_rsp_valid", o_valid, 0);
    check("rst_rsp_word", o_word, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_clocked", o_cs, 4'hF);
    check("rst_req_ready_clocked", o_ready, 0);
    rst_n = 1'b0;
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", o_ready, 1);
    check("rel_state", state_a, 0);

    // Settle 1, tick high: register 2 holds A5
    do_read(1'b0, 2, 1, 1, 0, -1, 8'h00);

    // Settle 3, tick every other cycle, bus changes to 3C mid-window
    tick_alt = 1'b1;
    do_read(1'b1, 1, 6, 6, 0, 1, 8'h3C);
    tick_alt = 1'b0;
    tick = 1'b1;

    // Consumer stalls for 5 cycles
    do_read(1'b0, 1, 1, 1, 5, -1, 8'h00);

    // Out-of-range address on the 3-register bus
    do_read(1'b1, 3, 0, 0, 1, -1, 8'h00);

    // Reset pulse while selecting
    sel = 1'b1;
    req_valid = 1'b1;
    req_addr  = 2'd0;
    step();
    req_valid = 1'b0;
    check("sel_before_rst", o_cs, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("async_cs_release", o_cs, 4'hF);
    check("async_state", state_b, 0);
    step();
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_valid) vcount++;
    end
    check("lost_req_no_rsp", vcount, 0);
    check("post_rst_ready", o_ready, 1);

    // Randomised reads on the 4-register bus
    for (int n = 0; n < 6; n++) begin
      ra = $urandom_range(0, 3);
      rh = $urandom_range(0, 3);
      regs_a[ra] = NB'($urandom_range(0, 255));
      do_read(1'b0, ra, 1, 1, rh, -1, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
